// File: rtl/mem_cmd_packer.sv
// mem_cmd_packer: coalesces single-word core writes into masked 16-byte line
// commands and issues line reads into the 179-bit command FIFO write port.
module mem_cmd_packer #(
  parameter int FLUSH_TIMEOUT = 8,
  parameter int CMD_WIDTH     = 179
) (
  input  logic                 clk_25MHz,
  input  logic                 rstn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  input  logic [3:0]           req_wstrb,
  output logic [CMD_WIDTH-1:0] fifo_data,
  output logic                 fifo_wr_en,
  input  logic                 fifo_full
);

  localparam logic [7:0] TIMEOUT  = 8'(FLUSH_TIMEOUT);
  localparam logic [2:0] OP_WRITE = 3'b001;
  localparam logic [2:0] OP_READ  = 3'b010;

  logic                 buf_valid_r;
  logic [27:0]          buf_line_r;
  logic [15:0]          buf_mask_r;
  logic [127:0]         buf_data_r;
  logic [7:0]           timer_r;
  logic                 out_valid_r;
  logic [CMD_WIDTH-1:0] out_data_r;
  logic                 ready_en_r;

  logic                 same_line_s;
  logic                 flush_s;
  logic                 out_free_s;
  logic                 do_flush_s;
  logic                 wr_acc_s;
  logic                 rd_acc_s;
  logic [15:0]          mask_next_s;
  logic [127:0]         data_next_s;

  assign fifo_data   = out_data_r;
  assign fifo_wr_en  = out_valid_r & ~fifo_full;
  assign out_free_s  = ~out_valid_r | fifo_wr_en;
  assign same_line_s = (req_addr[31:4] == buf_line_r);
  assign flush_s     = buf_valid_r & ((&buf_mask_r) | (timer_r == TIMEOUT) |
                                      (req_valid & ~req_we) |
                                      (req_valid & req_we & ~same_line_s));
  assign do_flush_s  = flush_s & out_free_s;
  assign wr_acc_s    = req_valid & req_ready & req_we;
  assign rd_acc_s    = req_valid & req_ready & ~req_we;

  // Request acceptance: reads wait until no write is pending ahead of them
  always_comb begin
    if (!ready_en_r) begin
      req_ready = 1'b0;
    end else if (req_we) begin
      req_ready = ~flush_s;
    end else begin
      req_ready = ~buf_valid_r & out_free_s;
    end
  end

  // Merge the incoming word into the line image; an empty buffer starts clean
  always_comb begin
    mask_next_s = buf_valid_r ? buf_mask_r : 16'h0000;
    data_next_s = buf_valid_r ? buf_data_r : 128'h0;
    for (int i = 0; i < 16; i++) begin
      if (((i / 4) == int'(req_addr[3:2])) && req_wstrb[i % 4]) begin
        mask_next_s[i]        = 1'b1;
        data_next_s[8*i +: 8] = req_wdata[8*(i % 4) +: 8];
      end else begin
        mask_next_s[i]        = mask_next_s[i];
      end
    end
  end

  // Hold off requests for one cycle after reset release
  always_ff @(posedge clk_25MHz or negedge rstn) begin
    if (!rstn) begin
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
    end
  end

  // Line buffer: accumulate same-line writes, age the line while idle
  always_ff @(posedge clk_25MHz or negedge rstn) begin
    if (!rstn) begin
      buf_valid_r <= 1'b0;
      buf_line_r  <= 28'h0;
      buf_mask_r  <= 16'h0000;
      buf_data_r  <= 128'h0;
      timer_r     <= 8'h00;
    end else if (do_flush_s) begin
      buf_valid_r <= 1'b0;
    end else if (wr_acc_s && (req_wstrb != 4'h0)) begin
      buf_valid_r <= 1'b1;
      buf_line_r  <= req_addr[31:4];
      buf_mask_r  <= mask_next_s;
      buf_data_r  <= data_next_s;
      timer_r     <= 8'h00;
    end else if (buf_valid_r && (timer_r != TIMEOUT)) begin
      timer_r     <= timer_r + 8'd1;
    end else begin
      timer_r     <= timer_r;
    end
  end

  // Output register: a flushed line takes priority, a read only loads when no line is held
  always_ff @(posedge clk_25MHz or negedge rstn) begin
    if (!rstn) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else if (do_flush_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= {OP_WRITE, buf_line_r, 4'h0, buf_mask_r, buf_data_r};
    end else if (rd_acc_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= {OP_READ, req_addr[31:4], 4'h0, 16'h0000, 128'h0};
    end else if (fifo_wr_en) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

endmodule

// File: tb/tb_mem_cmd_packer.sv
// Scoreboard bench for mem_cmd_packer: a transaction-level line model predicts
// every FIFO command; a monitor compares each fifo_wr_en beat against it.
module tb_mem_cmd_packer;

  localparam int FT = 8;

  logic         clk_25MHz = 1'b0;
  logic         rstn      = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_we    = 1'b0;
  logic [31:0]  req_addr  = 32'h0;
  logic [31:0]  req_wdata = 32'h0;
  logic [3:0]   req_wstrb = 4'h0;
  logic         fifo_full = 1'b0;
  logic         req_ready;
  logic         fifo_wr_en;
  logic [178:0] fifo_data;

  mem_cmd_packer #(.FLUSH_TIMEOUT(FT), .CMD_WIDTH(179)) dut (
    .clk_25MHz (clk_25MHz),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .fifo_data (fifo_data),
    .fifo_wr_en(fifo_wr_en),
    .fifo_full (fifo_full)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  int cyc = 0;
  always @(posedge clk_25MHz) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [178:0] act, input logic [178:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: one pending line, closed by read, other line, full mask or idle timeout
  logic [178:0] exp_q[$];
  bit           pend_v = 1'b0;
  logic [27:0]  pend_line;
  logic [15:0]  pend_m;
  logic [7:0]   pend_b[16];
  int           last_wr = 0;

  task automatic push_pend();
    logic [127:0] d;
    for (int i = 0; i < 16; i++) d[8*i +: 8] = pend_b[i];
    exp_q.push_back({3'b001, pend_line, 4'h0, pend_m, d});
    pend_v = 1'b0;
  endtask

  task automatic model(input bit acc);
    int slot;
    if (acc && !req_we) begin
      if (pend_v) push_pend();
      exp_q.push_back({3'b010, req_addr[31:4], 4'h0, 16'h0000, 128'h0});
    end else if (acc && req_wstrb != 4'h0) begin
      if (pend_v && pend_line != req_addr[31:4]) push_pend();
      if (!pend_v) begin
        pend_v    = 1'b1;
        pend_line = req_addr[31:4];
        pend_m    = 16'h0000;
        for (int i = 0; i < 16; i++) pend_b[i] = 8'h00;
      end
      slot = int'(req_addr[3:2]);
      for (int b = 0; b < 4; b++) begin
        if (req_wstrb[b]) begin
          pend_b[4*slot + b] = req_wdata[8*b +: 8];
          pend_m[4*slot + b] = 1'b1;
        end
      end
      last_wr = cyc;
      if (pend_m == 16'hFFFF) push_pend();
    end
    if (pend_v && (cyc - last_wr) > FT) push_pend();
  endtask

  // Monitor: every FIFO write must match the oldest expected command
  int           emit_cnt = 0;
  int           last_emit_cyc = -1;
  logic [178:0] last_emit_data = '0;
  always begin
    @(negedge clk_25MHz);
    #2;
    if (fifo_wr_en) begin
      emit_cnt++;
      last_emit_cyc  = cyc;
      last_emit_data = fifo_data;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_cmd: got %h expected no command (cycle %0d)", fifo_data, cyc);
      end else begin
        check("cmd", fifo_data, exp_q.pop_front());
      end
    end
  end

  task automatic step(input bit v, input bit we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input bit full, output bit acc);
    @(posedge clk_25MHz);
    #1;
    req_valid = v; req_we = we; req_addr = a; req_wdata = wd; req_wstrb = st; fifo_full = full;
    @(negedge clk_25MHz);
    acc = req_valid & req_ready;
    model(acc);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, acc);
  endtask

  initial begin
    #(40 * 20000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          acc, have, we, full;
    int          c0, nacc, e0;
    logic [31:0] a, wd, a_rd;
    logic [3:0]  st;
    logic [178:0] exp_word;

    // reset values and release latency
    @(negedge clk_25MHz);
    check("rst_ready", {178'h0, req_ready}, 179'h0);
    check("rst_wr_en", {178'h0, fifo_wr_en}, 179'h0);
    check("rst_data", fifo_data, 179'h0);
    @(posedge clk_25MHz); #1 rstn = 1'b1;
    @(negedge clk_25MHz);
    check("ready_after_release", {178'h0, req_ready}, 179'h0);
    idle(1);
    check("ready_second_cycle", {178'h0, req_ready}, 179'h1);

    // full-line coalescing
    nacc = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 32'h100 + 32'(4*k), 32'h11111111 * 32'(k+1), 4'hF, 1'b0, acc);
      nacc += int'(acc);
    end
    c0 = cyc;
    check("full_line_accepts", 179'(nacc), 179'd4);
    idle(5);
    check("full_line_timing", 179'(last_emit_cyc), 179'(c0 + 2));
    exp_word = {3'b001, 28'h0000010, 4'h0, 16'hFFFF, 128'h44444444_33333333_22222222_11111111};
    check("full_line_word", last_emit_data, exp_word);

    // partial line timeout
    step(1'b1, 1'b1, 32'h204, 32'hDEADBEEF, 4'b0011, 1'b0, acc);
    c0 = cyc;
    idle(FT + 4);
    check("partial_timing", 179'(last_emit_cyc), 179'(c0 + FT + 2));
    exp_word = {3'b001, 28'h0000020, 4'h0, 16'h0030, 128'h0000_0000_0000_0000_0000_BEEF_0000_0000};
    check("partial_word", last_emit_data, exp_word);

    // read behind a pending write
    step(1'b1, 1'b1, 32'h300, 32'hA5A55A5A, 4'hF, 1'b0, acc);
    c0 = cyc;
    step(1'b1, 1'b0, 32'h340, 32'h0, 4'h0, 1'b0, acc);
    check("read_held", 179'(acc), 179'd0);
    step(1'b1, 1'b0, 32'h340, 32'h0, 4'h0, 1'b0, acc);
    check("read_accepted", 179'(acc), 179'd1);
    idle(4);
    check("read_timing", 179'(last_emit_cyc), 179'(c0 + 3));
    exp_word = {3'b010, 28'h0000034, 4'h0, 16'h0000, 128'h0};
    check("read_word", last_emit_data, exp_word);

    // line change
    step(1'b1, 1'b1, 32'h400, 32'h01020304, 4'hF, 1'b0, acc);
    step(1'b1, 1'b1, 32'h410, 32'h05060708, 4'hF, 1'b0, acc);
    check("line_change_held", 179'(acc), 179'd0);
    step(1'b1, 1'b1, 32'h410, 32'h05060708, 4'hF, 1'b0, acc);
    check("line_change_accept", 179'(acc), 179'd1);
    idle(FT + 4);

    // FIFO backpressure
    nacc = 0; e0 = emit_cnt; a_rd = 32'h500;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0, a_rd, 32'h0, 4'h0, 1'b1, acc);
      if (acc) begin nacc++; a_rd = 32'h540; end
    end
    check("bp_accepts", 179'(nacc), 179'd1);
    check("bp_no_writes", 179'(emit_cnt - e0), 179'd0);
    check("bp_ready_low", {178'h0, req_ready}, 179'h0);
    step(1'b1, 1'b0, a_rd, 32'h0, 4'h0, 1'b0, acc);
    check("bp_release_wr_en", {178'h0, fifo_wr_en}, 179'h1);
    idle(4);

    // reset in the middle of an accumulating line
    step(1'b1, 1'b1, 32'h600, 32'hCAFEF00D, 4'hF, 1'b0, acc);
    idle(1);
    @(posedge clk_25MHz); #1 rstn = 1'b0; req_valid = 1'b0;
    #1;
    check("midrst_wr_en", {178'h0, fifo_wr_en}, 179'h0);
    check("midrst_data", fifo_data, 179'h0);
    check("midrst_ready", {178'h0, req_ready}, 179'h0);
    pend_v = 1'b0;
    exp_q.delete();
    e0 = emit_cnt;
    repeat (2) @(posedge clk_25MHz);
    @(posedge clk_25MHz); #1 rstn = 1'b1;
    @(negedge clk_25MHz);
    check("midrst_ready_release", {178'h0, req_ready}, 179'h0);
    idle(1);
    check("midrst_ready_back", {178'h0, req_ready}, 179'h1);
    idle(FT + 8);
    check("midrst_no_cmd", 179'(emit_cnt - e0), 179'd0);

    // randomized traffic over three neighbouring lines with held requests
    have = 1'b0; we = 1'b0; a = 32'h0; wd = 32'h0; st = 4'h0;
    for (int k = 0; k < 800; k++) begin
      if (!have && (k % 100) < 85 && $urandom_range(0, 9) < 7) begin
        have = 1'b1;
        we   = ($urandom_range(0, 9) < 8);
        a    = 32'h1000 + 32'($urandom_range(0, 2) * 16) + 32'($urandom_range(0, 3) * 4);
        wd   = $urandom;
        st   = 4'($urandom_range(1, 15));
      end
      full = ($urandom_range(0, 9) < 2);
      step(have, we, a, wd, st, full, acc);
      if (acc) have = 1'b0;
    end
    idle(FT + 30);
    check("drain_empty", 179'(exp_q.size()), 179'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
